// File: rtl/module_rgb_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : module_rgb_pwm_decoder
// Purpose  : Recovers the commanded RGB color from the 3-bit PWM waveform that
//            drives the LED. Each channel's high time is measured over a fixed
//            window and thresholded to on/off. A decoded color is committed
//            only after STABLE consecutive identical window results.
// Ports    : clk_i    - system clock, rising edge
//            rst_i    - asynchronous active-low reset
//            en_i     - measurement enable (low holds measurement cleared)
//            rgb_i    - PWM waveform, bit2=R, bit1=G, bit0=B
//            color_o  - last committed color
//            valid_o  - high once any color has been committed
//            change_o - one-cycle pulse on every commit
// Options  : RGB_DEC_SYNC_EN - when defined, rgb_i goes through a 2-flop
//            synchronizer per bit (adds 2 cycles of input latency). Leave it
//            undefined only when rgb_i is generated in the clk_i domain.
// Revision : 1.0 - initial release
// ============================================================================
module module_rgb_pwm_decoder #(
  parameter int unsigned WINDOW   = 100000,
  parameter int unsigned MIN_HIGH = 25000,
  parameter int unsigned STABLE   = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [2:0] rgb_i,
  output logic [2:0] color_o,
  output logic       valid_o,
  output logic       change_o
);

  localparam int unsigned WW = $clog2(WINDOW);
  localparam int unsigned HW = $clog2(WINDOW + 1);
  localparam int unsigned SW = $clog2(STABLE + 1);

  localparam logic [WW-1:0] c_WIN_LAST = WW'(WINDOW - 1);
  localparam logic [SW-1:0] c_SC_MAX   = SW'(STABLE);

  typedef enum logic [0:0] {
    ST_ACQ = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Input sampling
  // --------------------------------------------------------------------------
  logic [2:0] sample;

`ifdef RGB_DEC_SYNC_EN
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= rgb_i;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = rgb_i;
`endif

  // --------------------------------------------------------------------------
  // Window counter
  // --------------------------------------------------------------------------
  logic [WW-1:0] wcnt_q;
  logic [WW-1:0] wcnt_d;
  logic          eow;

  // A window only closes while enabled; dropping en_i on the last cycle
  // discards that window entirely.
  assign eow = en_i && (wcnt_q == c_WIN_LAST);

  always_comb begin
    wcnt_d = wcnt_q + WW'(1);
    if (!en_i || eow) begin
      wcnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel high counters and threshold
  // --------------------------------------------------------------------------
  logic [2:0] raw;

  for (genvar c = 0; c < 3; c++) begin : g_chan
    logic [HW-1:0] hcnt_q;
    logic [HW-1:0] hcnt_d;
    logic [HW:0]   total;

    // The closing cycle's sample is folded in here rather than stored, so the
    // stored count never exceeds WINDOW-1; the extra bit keeps WINDOW exact.
    assign total  = {1'b0, hcnt_q} + {{HW{1'b0}}, sample[c]};
    assign raw[c] = (32'(total) >= MIN_HIGH);

    always_comb begin
      hcnt_d = hcnt_q;
      if (!en_i || eow) begin
        hcnt_d = '0;
      end else if (sample[c]) begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        hcnt_q <= '0;
      end else begin
        hcnt_q <= hcnt_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Candidate / stability tracking
  // --------------------------------------------------------------------------
  logic [2:0]    cand_q;
  logic [2:0]    cand_d;
  logic [SW-1:0] sc_q;
  logic [SW-1:0] sc_d;

  always_comb begin
    cand_d = cand_q;
    sc_d   = sc_q;
    if (!en_i) begin
      sc_d = '0;
    end else if (eow) begin
      // sc==0 means no valid candidate yet, even if raw happens to equal it.
      if ((raw == cand_q) && (sc_q != '0)) begin
        sc_d = (sc_q == c_SC_MAX) ? sc_q : sc_q + SW'(1);
      end else begin
        cand_d = raw;
        sc_d   = SW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cand_q <= '0;
      sc_q   <= '0;
    end else begin
      cand_q <= cand_d;
      sc_q   <= sc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Commit state machine
  // --------------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic [2:0] color_q;
  logic [2:0] color_d;
  logic       change_q;
  logic       change_d;
  logic       commit;

  // A stable result equal to the already committed color is not re-committed.
  assign commit = eow && (sc_d == c_SC_MAX) &&
                  ((state_q == ST_ACQ) || (raw != color_q));

  always_comb begin
    state_d  = state_q;
    color_d  = color_q;
    change_d = 1'b0;
    if (commit) begin
      color_d  = raw;
      change_d = 1'b1;
      state_d  = ST_RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_ACQ;
      color_q  <= '0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      color_q  <= color_d;
      change_q <= change_d;
    end
  end

  assign color_o  = color_q;
  assign valid_o  = (state_q == ST_RUN);
  assign change_o = change_q;

endmodule
`default_nettype wire

// File: doc/module_rgb_pwm_decoder.md
# module_rgb_pwm_decoder

Reads back the 3-bit PWM waveform that drives the RGB LED and recovers the commanded color. It is the receiving end of the RGB color path: it lets the test harness and on-board self-check logic confirm which color the LED driver is producing. Each channel is measured over a fixed window and classified as on or off. A decoded color is committed only after it has been stable for a configurable number of windows.

## Interface
- WINDOW, 100000, clock cycles per measurement window (1 ms at 100 MHz); must be ≥ 2
- MIN_HIGH, 25000, minimum high cycles within a window for a channel to decode as on; range 1..WINDOW
- STABLE, 2, consecutive identical window results required before commit; must be ≥ 1
- clk_i  in  1  system clock; all logic on its rising edge
- rst_i  in  1  reset, asynchronous assert, active-low
- en_i  in  1  measurement enable; while low, measurement is held cleared
- rgb_i  in  3  PWM waveform: bit2=R, bit1=G, bit0=B
- color_o  out  3  last committed color
- valid_o  out  1  high once at least one color has been committed
- change_o  out  1  one-cycle pulse on every commit

## Operation
- Window counter wcnt, width $clog2(WINDOW). It counts 0..WINDOW-1, then wraps to 0.
- Three high counters hcnt[c], width $clog2(WINDOW+1). Each increments on a cycle where en_i=1 and the sampled rgb bit c=1.
- End of window is the cycle where en_i=1 and wcnt=WINDOW-1.
  - The sample from that cycle is included in the count.
  - raw[c] = (hcnt[c] + sample[c]) ≥ MIN_HIGH.
  - All hcnt clear to 0 on the following edge.
- Candidate register cand[2:0] and stability counter sc, width $clog2(STABLE+1). At end of window:
  - If raw==cand and sc≠0: sc ← min(sc+1, STABLE).
  - Otherwise: cand ← raw and sc ← 1.
- Commit condition: at end of window, next sc equals STABLE, and either valid_o=0 or raw≠color_o.
- On commit: color_o ← raw, valid_o ← 1, change_o ← 1 for exactly one cycle.
- If next sc equals STABLE and raw equals color_o, there is no commit, no pulse, and color_o holds.
- STABLE=1: every window whose result differs from color_o commits immediately.
- State machine:
  - ACQ: entered from reset; valid_o=0. Moves to RUN on the first commit.
  - RUN: stays in RUN until reset.
- en_i=0:
  - wcnt, all hcnt and sc clear to 0 on the next edge.
  - cand, color_o, valid_o and state hold.
  - change_o=0.
  - The first en_i=1 cycle counts as wcnt=0 of a fresh window.
- Reset (rst_i=0, at any time including mid-window):
  - color_o=0, valid_o=0, change_o=0.
  - wcnt, hcnt, sc and cand are 0; state is ACQ.
  - Synchronizer flops (if present) are 0.
  - Counting restarts with wcnt=0 on the first clock after rst_i deasserts.

## Timing
- Without synchronizer, sample = rgb_i of the same cycle.
- Commit edge: color_o, valid_o and change_o update on the rising edge that closes the qualifying window.
- Commit latency after reset with a constant input: STABLE×WINDOW cycles from the first counting cycle.
- A change in the input color is reflected after at most (STABLE+1)×WINDOW cycles.
- change_o is never high for two consecutive cycles, because WINDOW ≥ 2.
- Boundary values:
  - hcnt = WINDOW exactly: the channel is decoded on, with no overflow.
  - MIN_HIGH = WINDOW: only a channel held high for the full window decodes as on.
- en_i dropping on the end-of-window cycle: that window is not closed, and no commit occurs.

## Configuration
- RGB_DEC_SYNC_EN defined:
  - rgb_i passes through a 2-flop synchronizer per bit; the sample is the second flop's output.
  - All input-to-output latencies grow by 2 cycles.
  - Synchronizer flops reset to 0.
- RGB_DEC_SYNC_EN undefined: rgb_i is sampled directly. Use this only when rgb_i comes from logic clocked by clk_i.

## Test plan
All scenarios use WINDOW=8, MIN_HIGH=2 and STABLE=2 unless stated, with RGB_DEC_SYNC_EN undefined.
- Constant input, reset release: rgb_i=3'b101 and en_i=1 from the first cycle after reset. Expect change_o pulse and color_o=5, valid_o=1 on the edge closing window 2 (cycle 16); no pulse in later windows.
- Color change: after color 5 is committed, switch to rgb_i=3'b110. Expect window 3 raw=6 with sc=1 and no commit, then commit color_o=6 with one change_o pulse at the end of window 4.
- Duty threshold: channel R high 1 cycle per window decodes off; high 2 cycles decodes on; high 8 of 8 decodes on. Check color_o bit2 accordingly.
- Glitch rejection: a single window reading 3'b111 between windows reading 3'b101 gives no commit and no change_o; color_o stays 5.
- Mid-window disturbance:
  - en_i=0 for 3 cycles at wcnt=5: that window is discarded and a fresh 8-cycle window starts; color_o holds.
  - rst_i pulsed low mid-window: color_o=0, valid_o=0 immediately (asynchronously); recommit occurs 16 cycles after release.
- Synchronizer build: with RGB_DEC_SYNC_EN defined, repeat the first scenario. The commit edge is unchanged (cycle 16), but the window is built from inputs delayed 2 cycles: a 1-cycle R pulse placed at wcnt=7 is counted in the next window.
